// File: rtl/vscpu_pkg.sv
// Shared VerySimpleCPU definitions: address defaults, boot sequencer states
// and the instruction opcodes used to build program images.
package vscpu_pkg;

  localparam int          VS_SIZE         = 14;
  localparam logic [13:0] VS_MAILBOX_ADDR = 14'h3FFF;

  typedef enum logic [2:0] {
    BS_IDLE    = 3'd0,
    BS_LOAD    = 3'd1,
    BS_HOLD    = 3'd2,
    BS_RUN     = 3'd3,
    BS_DONE    = 3'd4,
    BS_TIMEOUT = 3'd5
  } boot_state_t;

  // Instruction word is {op[2:0], imm, A[13:0], B[13:0]}
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_SRL  = 3'd2;
  localparam logic [2:0] OP_LT   = 3'd3;
  localparam logic [2:0] OP_CP   = 3'd4;
  localparam logic [2:0] OP_CPI  = 3'd5;
  localparam logic [2:0] OP_BZJ  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  function automatic logic [31:0] vscpu_inst(input logic [2:0]  op,
                                             input logic        imm,
                                             input logic [13:0] a,
                                             input logic [13:0] b);
    return {op, imm, a, b};
  endfunction

endpackage

// File: rtl/vscpu_boot_ctrl_if.sv
// Load stream, CPU-side RAM request and RAM port of the boot controller.
// The slave modport is the controller; master is whoever drives it.
interface vscpu_boot_ctrl_if
  import vscpu_pkg::*;
#(
  parameter int SIZE = VS_SIZE
);
  logic            ld_valid;
  logic [31:0]     ld_data;
  logic            ld_last;
  logic            ld_ready;
  logic            cpu_wrEn;
  logic [SIZE-1:0] cpu_addr;
  logic [31:0]     cpu_data;
  logic            ram_wrEn;
  logic [SIZE-1:0] ram_addr;
  logic [31:0]     ram_data;

  modport slave (
    input  ld_valid, ld_data, ld_last, cpu_wrEn, cpu_addr, cpu_data,
    output ld_ready, ram_wrEn, ram_addr, ram_data
  );

  modport master (
    output ld_valid, ld_data, ld_last, cpu_wrEn, cpu_addr, cpu_data,
    input  ld_ready, ram_wrEn, ram_addr, ram_data
  );
endinterface

// File: rtl/vscpu_boot_ctrl.sv
// Boot/run sequencer: streams a host image into RAM, holds the CPU in reset,
// then hands it the RAM port until a mailbox write or the cycle budget ends the run.
module vscpu_boot_ctrl
  import vscpu_pkg::*;
#(
  parameter int              SIZE         = VS_SIZE,
  parameter logic [SIZE-1:0] MAILBOX_ADDR = SIZE'(VS_MAILBOX_ADDR),
  parameter logic [31:0]     MAX_CYCLES   = 32'd1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  vscpu_boot_ctrl_if.slave   bus,
  output logic               cpu_rst,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [31:0]        result
);

  localparam logic [2:0] S_IDLE    = BS_IDLE;
  localparam logic [2:0] S_LOAD    = BS_LOAD;
  localparam logic [2:0] S_HOLD    = BS_HOLD;
  localparam logic [2:0] S_RUN     = BS_RUN;
  localparam logic [2:0] S_DONE    = BS_DONE;
  localparam logic [2:0] S_TIMEOUT = BS_TIMEOUT;

  logic [2:0]      state_q,    state_d;
  logic [SIZE-1:0] load_ptr_q, load_ptr_d;
  logic [31:0]     cyc_cnt_q,  cyc_cnt_d;
  logic            hold_cnt_q, hold_cnt_d;
  logic            done_q,     done_d;
  logic            timeout_q,  timeout_d;
  logic [31:0]     result_q,   result_d;

  logic            ram_we;
  logic [SIZE-1:0] ram_a;
  logic [31:0]     ram_wd;

  always_comb begin
    state_d    = state_q;
    load_ptr_d = load_ptr_q;
    cyc_cnt_d  = cyc_cnt_q;
    hold_cnt_d = hold_cnt_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    result_d   = result_q;
    ram_we     = 1'b0;
    ram_a      = '0;
    ram_wd     = '0;

    case (state_q)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (start) begin
          state_d    = S_LOAD;
          load_ptr_d = '0;
          done_d     = 1'b0;
          timeout_d  = 1'b0;
          result_d   = '0;
        end
      end
      S_LOAD: begin
        if (bus.ld_valid) begin
          ram_we = 1'b1;
          ram_a  = load_ptr_q;
          ram_wd = bus.ld_data;
          // The top address is terminal: the pointer parks there instead of wrapping
          if (load_ptr_q != {SIZE{1'b1}}) begin
            load_ptr_d = load_ptr_q + 1'b1;
          end
          if (bus.ld_last || (load_ptr_q == {SIZE{1'b1}})) begin
            state_d    = S_HOLD;
            hold_cnt_d = 1'b0;
          end
        end
      end
      S_HOLD: begin
        cyc_cnt_d  = '0;
        hold_cnt_d = 1'b1;
        if (hold_cnt_q) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        ram_we = bus.cpu_wrEn;
        ram_a  = bus.cpu_addr;
        ram_wd = bus.cpu_data;
        if (cyc_cnt_q != 32'hFFFF_FFFF) begin
          cyc_cnt_d = cyc_cnt_q + 32'd1;
        end
        // Mailbox has priority over a budget expiring on the same cycle
        if (bus.cpu_wrEn && (bus.cpu_addr == MAILBOX_ADDR)) begin
          result_d = bus.cpu_data;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else if ((MAX_CYCLES != 32'd0) && (cyc_cnt_q == (MAX_CYCLES - 32'd1))) begin
          timeout_d = 1'b1;
          state_d   = S_TIMEOUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      load_ptr_q <= '0;
      cyc_cnt_q  <= '0;
      hold_cnt_q <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      load_ptr_q <= load_ptr_d;
      cyc_cnt_q  <= cyc_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      result_q   <= result_d;
    end
  end

  assign bus.ram_wrEn = ram_we;
  assign bus.ram_addr = ram_a;
  assign bus.ram_data = ram_wd;
  assign bus.ld_ready = (state_q == S_LOAD);

  assign cpu_rst = (state_q != S_RUN);
  assign busy    = (state_q == S_LOAD) || (state_q == S_HOLD) || (state_q == S_RUN);
  assign done    = done_q;
  assign timeout = timeout_q;
  assign result  = result_q;

endmodule

// File: tb/tb_vscpu_boot_ctrl.sv
// Self-checking bench for vscpu_boot_ctrl: the bench plays host, CPU and RAM,
// and predicts RAM contents and run outcome from the sequencing rules.
module tb_vscpu_boot_ctrl;
  import vscpu_pkg::*;

  localparam int          DEPTH   = 1 << VS_SIZE;
  localparam logic [13:0] MAILBOX = VS_MAILBOX_ADDR;
  localparam int          BUDGET  = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cpu_rst, busy, done, timeout;
  logic [31:0] result;

  vscpu_boot_ctrl_if #(.SIZE(VS_SIZE)) bus ();

  vscpu_boot_ctrl #(.MAX_CYCLES(32'(BUDGET))) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .done    (done),
    .timeout (timeout),
    .result  (result)
  );

  always #5 clk = ~clk;

  // Environment RAM written only through the DUT's RAM port
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int          wr_count = 0;

  always @(posedge clk) begin
    if (bus.ram_wrEn === 1'b1) begin
      mem[bus.ram_addr] <= bus.ram_data;
      wr_count          <= wr_count + 1;
    end
  end

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] img[$];
  bit          vpat[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start        = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = $urandom;
    bus.ld_last  = 1'b0;
    bus.cpu_wrEn = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_data = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_ld_ready", 32'(bus.ld_ready), 1);
    chk("start_busy", 32'(busy), 1);
    chk("start_cpu_rst", 32'(cpu_rst), 1);
    chk("start_flags", {30'd0, done, timeout}, 0);
    chk("start_result", result, 0);
  endtask

  // Streams img[0..n-1]; valid pattern from vpat, else random gaps
  task automatic load_image(input int n, input bit use_last, input int gap_pct);
    int i = 0;
    while (i < n) begin
      bit v;
      v = (vpat.size() > 0) ? vpat.pop_front() : ($urandom_range(99) >= gap_pct);
      bus.ld_valid = v;
      bus.ld_data  = v ? img[i] : $urandom;
      bus.ld_last  = v ? (use_last && (i == n - 1)) : 1'($urandom_range(1));
      #1;
      chk("ld_wren", 32'(bus.ram_wrEn), 32'(v));
      if (v) begin
        chk("ld_addr", 32'(bus.ram_addr), i);
        chk("ld_data", bus.ram_data, img[i]);
        ref_mem[i] = img[i];
        i++;
      end
      cyc();
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  // Called one edge after the final accepted word; CPU released on the third edge
  task automatic check_hold();
    chk("hold1_cpu_rst", 32'(cpu_rst), 1);
    chk("hold1_ld_ready", 32'(bus.ld_ready), 0);
    chk("hold1_busy", 32'(busy), 1);
    bus.ld_valid = 1'b1;
    bus.cpu_wrEn = 1'b1;
    bus.cpu_addr = 14'($urandom);
    #1;
    chk("hold_ram_quiet", 32'(bus.ram_wrEn), 0);
    cyc();
    chk("hold2_cpu_rst", 32'(cpu_rst), 1);
    idle_inputs();
    cyc();
    chk("run_cpu_rst", 32'(cpu_rst), 0);
    chk("run_busy", 32'(busy), 1);
  endtask

  task automatic cpu_cycle(input logic wr, input logic [13:0] a, input logic [31:0] d);
    bus.cpu_wrEn = wr;
    bus.cpu_addr = a;
    bus.cpu_data = d;
    #1;
    chk("run_pass", {bus.ram_wrEn, bus.ram_addr, 17'(bus.ram_data)}, {wr, a, 17'(d)});
    chk("run_pass_data", bus.ram_data, d);
    if (wr) ref_mem[a] = d;
    cyc();
    bus.cpu_wrEn = 1'b0;
  endtask

  task automatic cpu_random(input int n);
    for (int k = 0; k < n; k++) begin
      logic wr;
      wr = 1'($urandom_range(1));
      cpu_cycle(wr, 14'($urandom_range(32'h3FF0, 32'h3FFE)), $urandom);
    end
  endtask

  initial begin
    logic [31:0] w0, d;
    int          base;

    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    chk("rst_status", {28'd0, bus.ld_ready, busy, done, timeout}, 0);
    chk("rst_result", result, 0);
    chk("rst_ram", {bus.ram_wrEn, bus.ram_addr, 17'(bus.ram_data)}, 0);
    rst = 1'b0;
    bus.ld_valid = 1'b1;
    bus.cpu_wrEn = 1'b1;
    bus.cpu_addr = 14'($urandom);
    bus.cpu_data = $urandom;
    cyc();
    chk("idle_ram_quiet", 32'(bus.ram_wrEn), 0);
    chk("idle_ld_ready", 32'(bus.ld_ready), 0);
    idle_inputs();

    // Load and run with a 1,0,0,1,1 valid pattern
    do_start();
    img = '{vscpu_inst(OP_CP, 1'b1, MAILBOX, 14'h002A), $urandom, $urandom};
    chk("img_word0", img[0], 32'h9FFF_C02A);
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    base = wr_count;
    load_image(3, 1'b1, 0);
    check_hold();
    chk("bp_write_count", wr_count - base, 3);
    for (int i = 0; i < 3; i++) chk("bp_mem", mem[i], ref_mem[i]);
    cpu_random($urandom_range(1, 6));
    w0 = mem[0];
    if (w0[31:29] == OP_CP && w0[28]) cpu_cycle(1'b1, w0[27:14], 32'(w0[13:0]));
    chk("run_done", {30'd0, done, timeout}, 2);
    chk("run_result", result, 32'h2A);
    chk("run_cpu_rst_after", 32'(cpu_rst), 1);
    chk("mailbox_mem", mem[MAILBOX], 32'h2A);
    bus.cpu_wrEn = 1'b1;
    #1;
    chk("done_ram_quiet", 32'(bus.ram_wrEn), 0);
    idle_inputs();

    // Restart clears flags, then a BZJ loop exhausts the budget
    do_start();
    img = '{vscpu_inst(OP_BZJ, 1'b1, 14'd1, 14'd0), 32'd0};
    load_image(2, 1'b1, 40);
    check_hold();
    for (int k = 1; k <= BUDGET; k++) begin
      chk("to_pending", {30'd0, done, timeout}, 0);
      cpu_cycle(1'b0, 14'($urandom_range(1)), $urandom);
    end
    chk("to_flags", {30'd0, done, timeout}, 1);
    chk("to_cpu_rst", 32'(cpu_rst), 1);
    chk("to_busy", 32'(busy), 0);

    // Mailbox on the last budget cycle
    do_start();
    img = '{$urandom};
    load_image(1, 1'b1, 30);
    check_hold();
    for (int k = 1; k < BUDGET; k++) cpu_cycle(1'b0, 14'($urandom), $urandom);
    d = $urandom;
    cpu_cycle(1'b1, MAILBOX, d);
    chk("coll_flags", {30'd0, done, timeout}, 2);
    chk("coll_result", result, d);

    // Async reset between edges during RUN, then reload
    do_start();
    img = '{$urandom};
    load_image(1, 1'b1, 0);
    check_hold();
    cpu_random(3);
    #2 rst = 1'b1;
    #1;
    chk("arst_cpu_rst", 32'(cpu_rst), 1);
    chk("arst_status", {29'd0, busy, done, timeout}, 0);
    chk("arst_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("arst_idle", 32'(bus.ld_ready), 0);
    do_start();
    img = '{$urandom, $urandom};
    load_image(2, 1'b1, 20);
    check_hold();
    for (int i = 0; i < 2; i++) chk("reload_mem", mem[i], ref_mem[i]);

    // Full image with no ld_last
    rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    do_start();
    img = {};
    for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
    base = wr_count;
    load_image(DEPTH, 1'b0, 0);
    chk("full_write_count", wr_count - base, DEPTH);
    chk("full_hold_ready", 32'(bus.ld_ready), 0);
    bus.ld_valid = 1'b1;
    bus.ld_data  = $urandom;
    #1;
    chk("full_no_wrap", 32'(bus.ram_wrEn), 0);
    bus.ld_valid = 1'b0;
    check_hold();
    chk("full_mem0", mem[0], ref_mem[0]);
    chk("full_mem_top", mem[DEPTH - 1], ref_mem[DEPTH - 1]);
    for (int k = 0; k < 4; k++) begin
      int a;
      a = $urandom_range(DEPTH - 1);
      chk("full_mem_rand", mem[a], ref_mem[a]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vscpu_boot_ctrl.md
# vscpu_boot_ctrl

Boot and run sequencer for the VerySimpleCPU subsystem. Owns the single RAM port. In load mode it writes a host word stream into RAM from address 0. It then releases the CPU from reset and passes the CPU's RAM requests straight through. It ends the run when the CPU writes a mailbox address or a cycle budget expires.

## Interface
- `SIZE`, 14: RAM address width, matching the CPU.
- `MAILBOX_ADDR`, 14'h3FFF: a CPU write to this address ends the run.
- `MAX_CYCLES`, 32'd1_000_000: run-cycle budget; 0 disables the timeout.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level-sampled; begins a load from IDLE, DONE or TIMEOUT.
- `ld_valid`  in  1  load word valid.
- `ld_data`  in  32  load word.
- `ld_last`  in  1  marks the final load word; qualified by `ld_valid`.
- `ld_ready`  out  1  controller accepts a load word.
- `cpu_rst`  out  1  drives the CPU's synchronous `rst`.
- `cpu_wrEn`  in  1  CPU RAM write enable.
- `cpu_addr`  in  SIZE  CPU RAM address.
- `cpu_data`  in  32  CPU RAM write data.
- `ram_wrEn`  out  1  RAM write enable.
- `ram_addr`  out  SIZE  RAM address.
- `ram_data`  out  32  RAM write data.
- `busy`  out  1  high in LOAD, HOLD and RUN.
- `done`  out  1  run ended by a mailbox write.
- `timeout`  out  1  run ended by budget expiry.
- `result`  out  32  data captured from the mailbox write.

## Operation
States: IDLE, LOAD, HOLD, RUN, DONE, TIMEOUT.

- **IDLE**
  - `cpu_rst`=1; RAM outputs all 0.
  - `start`=1 → LOAD: clear `load_ptr`, `done`, `timeout`, `result`.
- **LOAD**
  - `ld_ready`=1; `cpu_rst`=1.
  - On `ld_valid`: `ram_wrEn`=1, `ram_addr`=`load_ptr`, `ram_data`=`ld_data`, and `load_ptr` increments.
  - These RAM outputs are combinational from `ld_valid`.
  - Accepting a word with `ld_last`=1 → HOLD.
  - Accepting the word at `load_ptr` = 2^SIZE-1 → HOLD, with or without `ld_last`. The pointer never wraps.
- **HOLD**
  - Exactly 2 cycles; `cpu_rst`=1 and RAM outputs 0.
  - Guarantees at least one CPU clock edge in synchronous reset, then → RUN.
  - Clear `cyc_cnt`.
- **RUN**
  - `cpu_rst`=0.
  - RAM outputs equal the CPU inputs combinationally, with no added latency. RAM read data reaches the CPU directly, outside this block.
  - `cyc_cnt` increments every cycle.
  - `cpu_wrEn`=1 and `cpu_addr`=`MAILBOX_ADDR`: the write still passes to RAM that cycle. `result` ← `cpu_data`, then → DONE.
  - Otherwise, if `MAX_CYCLES`≠0 and `cyc_cnt`=`MAX_CYCLES`-1 → TIMEOUT.
  - Mailbox and timeout in the same cycle: the mailbox wins, giving DONE.
- **DONE / TIMEOUT**
  - `cpu_rst`=1; RAM outputs 0.
  - `done` (resp. `timeout`) is held at 1 and `result` is held.
  - `start`=1 → LOAD; flags and `result` clear on that edge.
- `start` is ignored in LOAD, HOLD and RUN.
- `ld_valid` is ignored outside LOAD, since `ld_ready`=0 there.

## Timing
- Reset values:
  - state IDLE; `cpu_rst`=1; `ld_ready`=0; `busy`=0; `done`=0; `timeout`=0.
  - `result`=0; `ram_wrEn`=0; `ram_addr`=0; `ram_data`=0.
  - `load_ptr`=0; `cyc_cnt`=0.
- A load word transfers on any edge with `ld_valid`&&`ld_ready`. The RAM write happens on that same edge.
- Latency:
  - `start` → LOAD: 1 cycle.
  - Last word accepted → `cpu_rst` falls: 3 edges (HOLD×2, then RUN).
  - Mailbox write → `done` high: next edge.
- `done`, `timeout`, `busy`, `cpu_rst`, `ld_ready` and `result` are functions of registered state only. The RAM outputs are combinational muxes.
- `rst` asserted mid-LOAD or mid-RUN: immediately IDLE with all reset values.
  - `cpu_rst` rises asynchronously.
  - RAM contents are not cleared.
- `cyc_cnt` is 32 bits and saturates; it never wraps.

## Structure
- Shared package `vscpu_pkg`:
  - `SIZE` default.
  - `MAILBOX_ADDR` default.
  - Boot state enum `boot_state_t`.
  - CPU opcode constants, reused by benches for program images.
- No sub-module. The RAM port mux, the load pointer and the cycle counter are all inline.

## Test plan
- **Load and run:** reset, `start`, load 3 words (program: CPi [0x3FFF] ← 0x2A, i.e. `ld_data`=0x9FFFC02A, then two fillers) with `ld_last` on word 3.
  - RAM[0..2] must match the loaded words.
  - `cpu_rst` falls 3 edges after the last word.
  - `done`=1, `result`=0x2A, and RAM[0x3FFF]=0x2A.
- **Backpressure gaps:** `ld_valid` toggled 1,0,0,1,1 with `ld_last` on the final word.
  - Exactly 3 RAM writes at addresses 0,1,2.
  - No write on idle cycles.
- **Timeout:** `MAX_CYCLES`=100 with a program that loops on BZJ and never writes the mailbox.
  - `timeout`=1 after exactly 100 RUN cycles, `done`=0, `cpu_rst`=1.
- **Full image:** stream 2^14 words with no `ld_last`.
  - HOLD is entered after word 16383.
  - `ld_ready`=0 afterwards and no pointer wrap to 0.
- **Async reset mid-RUN:** assert `rst` between clock edges during RUN.
  - `cpu_rst`=1 immediately, state IDLE, `done`=`timeout`=0, `result`=0.
  - A subsequent `start` reloads correctly.
- **Collision:** mailbox write on the same cycle the budget expires gives `done`=1 and `timeout`=0.
- **Restart:** `start` in DONE clears `done` and `result` on the next edge.
